shift_row_unit: RTL
===================

// Module: shift_row_unit
// PURPOSE
//  Parametrised Rijndael ShiftRows/InvShiftRows stage for 128/192/256-bit blocks (NB columns).
//  Direction is selectable per block. Blocks enter on a valid/ready handshake.
//  Results drain through a DEPTH-entry output FIFO, so the stage sits between SubBytes and
//  MixColumns in a round pipeline and absorbs downstream stalls.
// PARAMETERS
//  NB     4   state columns: 4, 6 or 8 (block = 32*NB bits); any other value -> elaboration $error
//  DEPTH  2   output FIFO entries, 1..8
//  CNT_W  16  width of blockCount
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous, active-low reset
//  inValid     in   1       inputData/inverse valid
//  inReady     out  1       unit can accept a block this cycle
//  inputData   in   32*NB   state, column-major; byte k=4*c+r at bits [32*NB-1-8k -: 8]
//  inverse     in   1       0 = ShiftRows, 1 = InvShiftRows; sampled with the block
//  outValid    out  1       outputData/outInverse valid
//  outReady    in   1       downstream accepts the head entry
//  outputData  out  32*NB   shifted state, same byte ordering
//  outInverse  out  1       inverse flag that travelled with the block
//  blockCount  out  CNT_W   blocks accepted since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Row offsets s(r): NB=4/6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}.
//  - Forward: out[r][c] = in[r][(c+s(r)) mod NB]. Inverse: out[r][c] = in[r][(c-s(r)) mod NB].
//  - Permutation is combinational on inputData. The result and inverse are written into the
//    FIFO on accept (inValid && inReady) at the rising edge.
//  - Latency: block accepted at edge N -> outValid=1 with the data after edge N, if the FIFO was empty.
//  - inReady = (count < DEPTH). It is a registered-state function only; there is no
//    combinational path from outReady.
//  - outValid = (count != 0). outputData/outInverse show the head entry and are stable while
//    outValid && !outReady.
//  - Pop when outValid && outReady. Simultaneous push and pop (count<DEPTH, count>0):
//    count is unchanged, order is preserved.
//  - Full (count==DEPTH): inReady=0; inValid is ignored. A pop that cycle frees one slot for the next cycle.
//  - Empty: outReady is ignored; the read pointer does not move.
//  - Pointers wrap modulo DEPTH. count has range 0..DEPTH.
//  - blockCount increments by 1 per accepted block and wraps from 2^CNT_W-1 to 0.
//  - Reset (async assert, any time including mid-stream):
//    count=0, pointers=0, outValid=0, inReady=1, blockCount=0, outputData=0, outInverse=0.
//    In-flight blocks are discarded.
//  - After reset_n deasserts, the first accept can occur on the next rising edge.
//  - No X propagation: storage and outputs are zero-initialised on reset.
// TESTING
//  1 NB=4 fwd: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 ->
//    d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5; outValid 1 cycle after accept.
//  2 NB=4 inv: feed the test-1 output with inverse=1 -> original test-1 input; outInverse=1.
//  3 NB=8 fwd, bytes 00..1f -> first column 00 05 0e 13. Then inv on that result -> 00..1f restored.
//  4 DEPTH=2, outReady=0, push 3 back-to-back -> inReady=0 after 2 accepts, 3rd held.
//    Release outReady -> 3 blocks out in order, blockCount=3.
//  5 Count=1, inValid=1 and outReady=1 every cycle for 10 cycles -> count stays 1, 1 block/cycle,
//    order kept, no inReady drop.
//  6 Assert reset_n=0 mid-stream with 2 entries and no clock edge -> outValid=0, inReady=1,
//    blockCount=0 immediately; after release, next block has latency 1.

Source files
------------

// File: rtl/shift_row_unit.sv
// Rijndael ShiftRows / InvShiftRows stage for NB = 4, 6 or 8 columns,
// with a valid/ready input and a DEPTH-entry output FIFO that absorbs downstream stalls.
module shift_row_unit #(
  parameter int NB    = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [32*NB-1:0]   inputData,
  input  logic               inverse,
  output logic               outValid,
  input  logic               outReady,
  output logic [32*NB-1:0]   outputData,
  output logic               outInverse,
  output logic [CNT_W-1:0]   blockCount
);

  localparam int W     = 32 * NB;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_row_unit: NB must be 4, 6 or 8");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("shift_row_unit: DEPTH must be in 1..8");
  end

  // Rows 2 and 3 shift one column further for the 256-bit block.
  function automatic int row_offset(input int r);
    if (NB == 8 && r >= 2) begin
      return r + 1;
    end else begin
      return r;
    end
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [W-1:0]       shifted_s;
  logic               push_s;
  logic               pop_s;
  logic [W-1:0]       data_q [DEPTH];
  logic [DEPTH-1:0]   inv_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  // Byte permutation of the incoming state; byte k = 4*c + r sits at the MSB end for k = 0.
  always_comb begin
    shifted_s = {W{1'b0}};
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inverse) begin
          shifted_s[W-1-8*(4*c+r) -: 8] = inputData[W-1-8*(4*((c - row_offset(r) + NB) % NB)+r) -: 8];
        end else begin
          shifted_s[W-1-8*(4*c+r) -: 8] = inputData[W-1-8*(4*((c + row_offset(r)) % NB)+r) -: 8];
        end
      end
    end
  end

  assign inReady    = (count_q < CW'(DEPTH));
  assign outValid   = (count_q != {CW{1'b0}});
  assign push_s     = inValid && inReady;
  assign pop_s      = outValid && outReady;
  assign outputData = data_q[rd_ptr_q];
  assign outInverse = inv_q[rd_ptr_q];
  assign blockCount = blk_cnt_q;

  // FIFO pointer, occupancy and block counter next state.
  always_comb begin
    wr_ptr_d  = push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
    blk_cnt_d = push_s ? blk_cnt_q + CNT_W'(1) : blk_cnt_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers and FIFO storage, all zeroed on reset so nothing stale leaks out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CW{1'b0}};
      blk_cnt_q <= {CNT_W{1'b0}};
      inv_q     <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      blk_cnt_q <= blk_cnt_d;
      if (push_s) begin
        data_q[wr_ptr_q] <= shifted_s;
        inv_q[wr_ptr_q]  <= inverse;
      end
    end
  end

endmodule
